// File: rtl/dff_re_reg_if.sv
// Port bundle for the enabled register: load enable and data in, stored value out.
interface dff_re_reg_if #(
    parameter int unsigned WIDTH = 1
);
    logic             enable;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    modport master (output enable, output d, input q);
    modport slave  (input enable, input d, output q);
endinterface

// File: rtl/dff_re_reg.sv
// Rising-edge register with clock enable and asynchronous active-high reset.
// Basic storage element for control/status bits and pipeline stages.
module dff_re_reg #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic        clk,
    input  logic        rst,
    dff_re_reg_if.slave bus
);

    if (WIDTH < 1) begin : g_width_check
        $error("dff_re_reg: WIDTH must be at least 1");
    end

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Next value: capture d when enabled, otherwise recirculate.
    always_comb begin
        q_d = q_q;
        if (bus.enable) begin
            q_d = bus.d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.q = q_q;

`ifndef SYNTHESIS
    a_reset_holds : assert property (@(posedge clk) rst |-> (q_q == RESET_VAL));

    a_hold_when_disabled : assert property (@(posedge clk) disable iff (rst)
        !bus.enable |=> (q_q == $past(q_q)));
`endif

endmodule

// File: tb/tb_dff_re_reg.sv
// Bench for dff_re_reg: directed tables for WIDTH=1/RESET_VAL=0 and
// WIDTH=8/RESET_VAL=8'hA5, then randomized stimulus against a stored-value model.
module tb_dff_re_reg;

    localparam logic [7:0] RV8 = 8'hA5;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] d;
        logic [7:0] exp_pre;
        logic [7:0] exp_post;
    } vec_t;

    logic clk;
    logic rst1;
    logic rst8;
    int   errors;
    int   checks;

    dff_re_reg_if #(.WIDTH(1)) bus1 ();
    dff_re_reg_if #(.WIDTH(8)) bus8 ();

    dff_re_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    dff_re_reg #(.WIDTH(8), .RESET_VAL(RV8)) u_dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    vec_t vec1 [10];
    vec_t vec8 [5];

    logic       m1;
    logic [7:0] m8;
    logic       r1, e1, dd1;
    logic       r8, e8;
    logic [7:0] dd8;

    initial begin
        errors = 0;
        checks = 0;

        // Stimulus applied at 10i ns; pre sampled at 10i+1, post after the 10i+5 edge.
        vec1[0] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        vec1[1] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        vec1[2] = '{1'b0, 1'b0, 8'h01, 8'h00, 8'h00};
        vec1[3] = '{1'b0, 1'b1, 8'h01, 8'h00, 8'h01};
        vec1[4] = '{1'b0, 1'b1, 8'h00, 8'h01, 8'h00};
        vec1[5] = '{1'b0, 1'b0, 8'h01, 8'h00, 8'h00};
        vec1[6] = '{1'b0, 1'b1, 8'h01, 8'h00, 8'h01};
        vec1[7] = '{1'b1, 1'b1, 8'h01, 8'h00, 8'h00};
        vec1[8] = '{1'b0, 1'b1, 8'h01, 8'h00, 8'h01};
        vec1[9] = '{1'b0, 1'b1, 8'h00, 8'h01, 8'h00};

        vec8[0] = '{1'b1, 1'b1, 8'h3C, RV8,   RV8};
        vec8[1] = '{1'b0, 1'b1, 8'h3C, RV8,   8'h3C};
        vec8[2] = '{1'b0, 1'b0, 8'hFF, 8'h3C, 8'h3C};
        vec8[3] = '{1'b1, 1'b1, 8'hFF, RV8,   RV8};
        vec8[4] = '{1'b0, 1'b0, 8'hFF, RV8,   RV8};

        rst8        = 1'b1;
        bus8.enable = 1'b0;
        bus8.d      = 8'h00;

        for (int i = 0; i < 10; i++) begin
            rst1        = vec1[i].rst;
            bus1.enable = vec1[i].en;
            bus1.d      = vec1[i].d[0];
            #1;
            check($sformatf("w1_pre[%0d]", i), 8'(bus1.q), vec1[i].exp_pre);
            #8;
            check($sformatf("w1_post[%0d]", i), 8'(bus1.q), vec1[i].exp_post);
            #1;
        end

        rst1        = 1'b0;
        bus1.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rst8        = vec8[i].rst;
            bus8.enable = vec8[i].en;
            bus8.d      = vec8[i].d;
            #1;
            check($sformatf("w8_pre[%0d]", i), bus8.q, vec8[i].exp_pre);
            #8;
            check($sformatf("w8_post[%0d]", i), bus8.q, vec8[i].exp_post);
            #1;
        end

        // Random phase: reference is the stored value, reset to RESET_VAL, replaced on enabled edges.
        m1 = 1'b0;
        m8 = RV8;
        for (int j = 0; j < 300; j++) begin
            r1  = (j == 0) || ($urandom_range(7) == 0);
            r8  = (j == 0) || ($urandom_range(7) == 0);
            e1  = 1'($urandom_range(1));
            e8  = 1'($urandom_range(1));
            dd1 = 1'($urandom_range(1));
            dd8 = 8'($urandom_range(255));
            rst1 = r1; bus1.enable = e1; bus1.d = dd1;
            rst8 = r8; bus8.enable = e8; bus8.d = dd8;
            if (r1) m1 = 1'b0;
            if (r8) m8 = RV8;
            #1;
            check("rnd1_pre", 8'(bus1.q), 8'(m1));
            check("rnd8_pre", bus8.q, m8);
            #4;
            if (!r1 && e1) m1 = dd1;
            if (!r8 && e8) m8 = dd8;
            #2;
            // Inputs wiggle between edges; q must not follow them.
            bus1.enable = 1'($urandom_range(1));
            bus1.d      = ~dd1;
            bus8.enable = 1'($urandom_range(1));
            bus8.d      = ~dd8;
            #2;
            check("rnd1_post", 8'(bus1.q), 8'(m1));
            check("rnd8_post", bus8.q, m8);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
